// File: rtl/perf_cnt.sv
// perf_cnt: parametrised performance counter.
//   Counts clock cycles and retired instructions per execute channel. A rising
//   edge on any read bit snapshots all counters and streams them out over a
//   valid/ready port: beat 0 = cycles, beat 1 = total, beat 2+i = channel i.
//   Build option PERF_CNT_SAT_EN: counters and total saturate at 2^CW-1
//   instead of wrapping.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   ex[NCH]           per-channel retire strobe (rising edge = 1 instruction)
//   read[NCH]         report request (rising edge on any bit)
//   clear             synchronous clear of live counters
//   rd_valid/rd_ready beat handshake
//   rd_idx, rd_data   beat index and payload
//   rd_last           final beat marker
//   busy              report in progress (SNAP or SEND)

// Per-channel retire counter with its own edge detector.
module perf_cnt_lane #(
    parameter int CW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ex,
    input  logic          clear,
    output logic [CW-1:0] cnt
);
    logic ex_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q <= 1'b0;
            cnt  <= '0;
        end else begin
            ex_q <= ex;
            if (clear)
                cnt <= '0;
            else if (ex & ~ex_q) begin
`ifdef PERF_CNT_SAT_EN
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
`else
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end
endmodule

module perf_cnt #(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] ex,
    input  logic [NCH-1:0] read,
    input  logic           clear,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [4:0]     rd_idx,
    output logic [CW-1:0]  rd_data,
    output logic           rd_last,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    localparam logic [4:0] LAST = 5'(NCH + 1);
    // The total needs headroom above CW only to detect saturation.
`ifdef PERF_CNT_SAT_EN
    localparam int SW = CW + 5;
`else
    localparam int SW = CW;
`endif
    localparam logic [SW-1:0] MAXV = SW'({CW{1'b1}});

    state_t                  state, state_n;
    logic [NCH-1:0]          read_q;
    logic                    rd_req;
    logic                    pend;
    logic [CW-1:0]           cyc;
    logic [NCH-1:0][CW-1:0]  ins;
    logic [SW-1:0]           sum;
    logic [CW-1:0]           total;
    logic [CW-1:0]           snap_cyc;
    logic [CW-1:0]           snap_tot;
    logic [NCH-1:0][CW-1:0]  snap_ins;
    logic [CW-1:0]           sel;

    assign rd_req = |(read & ~read_q);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_lane
            perf_cnt_lane #(.CW(CW)) u_lane (
                .clock (clock),
                .reset (reset),
                .ex    (ex[g]),
                .clear (clear),
                .cnt   (ins[g])
            );
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++)
            sum = sum + SW'(ins[i]);
`ifdef PERF_CNT_SAT_EN
        total = (sum >= MAXV) ? {CW{1'b1}} : sum[CW-1:0];
`else
        total = sum;
`endif
    end

    // Live cycle counter and request edge register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc    <= '0;
            read_q <= '0;
        end else begin
            read_q <= read;
            if (clear)
                cyc <= '0;
`ifdef PERF_CNT_SAT_EN
            else if (cyc != '1)
                cyc <= cyc + 1'b1;
`else
            else
                cyc <= cyc + 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: if (rd_req | pend) state_n = SNAP;
            SNAP: begin
                busy    = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                rd_last  = (rd_idx == LAST);
                if (rd_ready && rd_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Beat index, pending request and snapshots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx   <= '0;
            pend     <= 1'b0;
            snap_cyc <= '0;
            snap_tot <= '0;
            snap_ins <= '0;
        end else begin
            // In IDLE any request launches SNAP directly, so pend is consumed.
            if (state == IDLE)
                pend <= 1'b0;
            else if (rd_req)
                pend <= 1'b1;
            if (state == SNAP) begin
                snap_cyc <= cyc;
                snap_tot <= total;
                snap_ins <= ins;
                rd_idx   <= '0;
            end else if (state == SEND && rd_ready) begin
                rd_idx <= (rd_idx == LAST) ? 5'd0 : rd_idx + 5'd1;
            end
        end
    end

    always_comb begin
        sel = snap_cyc;
        if (rd_idx == 5'd1)
            sel = snap_tot;
        for (int i = 0; i < NCH; i++)
            if (rd_idx == 5'(i + 2))
                sel = snap_ins[i];
    end

    assign rd_data = (state == SEND) ? sel : '0;
endmodule

// File: tb/tb_perf_cnt.sv
// tb_perf_cnt: directed bench for perf_cnt. Instance u0 is NCH=4/CW=32,
// instance u1 is NCH=2/CW=4 for the narrow wrap/saturation case. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_perf_cnt;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ex, read;
    logic        clear, rd_ready;
    logic        rd_valid, rd_last, busy;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;

    logic [1:0]  ex2, read2;
    logic        clear2, rdy2;
    logic        rd_valid2, rd_last2, busy2;
    logic [4:0]  rd_idx2;
    logic [3:0]  rd_data2;

    int vectors = 0;
    int errs    = 0;
    int exp5;

    perf_cnt #(.NCH(4), .CW(32)) u0 (
        .clock(clock), .reset(reset), .ex(ex), .read(read), .clear(clear),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
    );

    perf_cnt #(.NCH(2), .CW(4)) u1 (
        .clock(clock), .reset(reset), .ex(ex2), .read(read2), .clear(clear2),
        .rd_valid(rd_valid2), .rd_ready(rdy2), .rd_idx(rd_idx2),
        .rd_data(rd_data2), .rd_last(rd_last2), .busy(busy2)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one u0 beat at the current sample point, then advance a clock.
    task automatic beat(input string tag, input int idx, input logic [31:0] data, input logic last);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_idx"},   32'(rd_idx),   32'(idx));
        chk({tag, "_data"},  rd_data,       data);
        chk({tag, "_last"},  32'(rd_last),  32'(last));
        step();
    endtask

    task automatic beat2(input string tag, input int idx, input logic [3:0] data, input logic last, input bit cd);
        chk({tag, "_valid"}, 32'(rd_valid2), 32'd1);
        chk({tag, "_idx"},   32'(rd_idx2),   32'(idx));
        if (cd) chk({tag, "_data"}, 32'(rd_data2), 32'(data));
        chk({tag, "_last"},  32'(rd_last2),  32'(last));
        step();
    endtask

    initial begin
        reset = 1'b1; ex = '0; read = '0; clear = 1'b0; rd_ready = 1'b1;
        ex2 = '0; read2 = '0; clear2 = 1'b0; rdy2 = 1'b1;
        step(); step();
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_idx",   32'(rd_idx),   32'd0);
        chk("rst_data",  rd_data,       32'd0);
        chk("rst_last",  32'(rd_last),  32'd0);

        // 1: ex[0] high 3 cycles from reset release, read at 10 clocks
        reset = 1'b0; ex = 4'b0001;
        repeat (3) step();
        ex = '0;
        repeat (7) step();
        read = 4'b0001;
        step(); read = '0;
        chk("t1_snap_busy",  32'(busy),     32'd1);
        chk("t1_snap_valid", 32'(rd_valid), 32'd0);
        step();
        beat("t1_b0", 0, 32'd11, 1'b0);
        beat("t1_b1", 1, 32'd1,  1'b0);
        beat("t1_b2", 2, 32'd1,  1'b0);
        beat("t1_b3", 3, 32'd0,  1'b0);
        beat("t1_b4", 4, 32'd0,  1'b0);
        beat("t1_b5", 5, 32'd0,  1'b1);
        chk("t1_end_valid", 32'(rd_valid), 32'd0);
        chk("t1_end_busy",  32'(busy),     32'd0);

        // 2: clear, toggle all channels 5 times, read[2]
        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ex = 4'hF; step(); ex = '0; step();
        end
        read = 4'b0100;
        step(); read = '0;
        chk("t2_lat_valid", 32'(rd_valid), 32'd0);
        step();
        beat("t2_b0", 0, 32'd11, 1'b0);
        beat("t2_b1", 1, 32'd20, 1'b0);
        beat("t2_b2", 2, 32'd5,  1'b0);
        beat("t2_b3", 3, 32'd5,  1'b0);
        beat("t2_b4", 4, 32'd5,  1'b0);
        beat("t2_b5", 5, 32'd5,  1'b1);
        chk("t2_end_valid", 32'(rd_valid), 32'd0);

        // 3: back-pressure at idx2, live clear during the stall
        read = 4'b0010;
        step(); read = '0; step();
        beat("t3_b0", 0, 32'd19, 1'b0);
        beat("t3_b1", 1, 32'd20, 1'b0);
        rd_ready = 1'b0;
        for (int j = 0; j < 7; j++) begin
            chk("t3_stall_valid", 32'(rd_valid), 32'd1);
            chk("t3_stall_idx",   32'(rd_idx),   32'd2);
            chk("t3_stall_data",  rd_data,       32'd5);
            chk("t3_stall_last",  32'(rd_last),  32'd0);
            clear = (j == 3);
            step();
        end
        clear = 1'b0; rd_ready = 1'b1;
        beat("t3_b2", 2, 32'd5, 1'b0);
        beat("t3_b3", 3, 32'd5, 1'b0);
        beat("t3_b4", 4, 32'd5, 1'b0);
        beat("t3_b5", 5, 32'd5, 1'b1);
        chk("t3_end_valid", 32'(rd_valid), 32'd0);

        // 4: two requests during SEND collapse into one follow-up report
        clear = 1'b1; step(); clear = 1'b0;
        read = 4'b1000;
        step(); read = '0; step();
        read = 4'b0001;
        beat("t4_b0", 0, 32'd1, 1'b0);
        read = '0;
        beat("t4_b1", 1, 32'd0, 1'b0);
        read = 4'b0010;
        beat("t4_b2", 2, 32'd0, 1'b0);
        read = '0;
        beat("t4_b3", 3, 32'd0, 1'b0);
        beat("t4_b4", 4, 32'd0, 1'b0);
        beat("t4_b5", 5, 32'd0, 1'b1);
        chk("t4_gap_valid", 32'(rd_valid), 32'd0);
        chk("t4_gap_busy",  32'(busy),     32'd0);
        step();
        chk("t4_fu_busy",  32'(busy),     32'd1);
        chk("t4_fu_valid", 32'(rd_valid), 32'd0);
        step();
        beat("t4_f0", 0, 32'd9, 1'b0);
        beat("t4_f1", 1, 32'd0, 1'b0);
        beat("t4_f2", 2, 32'd0, 1'b0);
        beat("t4_f3", 3, 32'd0, 1'b0);
        beat("t4_f4", 4, 32'd0, 1'b0);
        beat("t4_f5", 5, 32'd0, 1'b1);
        chk("t4_fend_valid", 32'(rd_valid), 32'd0);
        step(); step();
        chk("t4_no_second", 32'(busy), 32'd0);

        // clear, read edge and ex edge on the same clock: snapshot sees zeros
        clear = 1'b1; read = 4'b0001; ex = 4'b0001;
        step(); clear = 1'b0; read = '0; step();
        beat("tc_b0", 0, 32'd0, 1'b0);
        read = 4'b0010;
        beat("tc_b1", 1, 32'd0, 1'b0);
        read = '0;
        beat("tc_b2", 2, 32'd0, 1'b0);

        // 6: reset at idx3 with a request pending
        chk("t6_pre_idx", 32'(rd_idx), 32'd3);
        reset = 1'b1; ex = '0;
        #1;
        chk("t6_async_valid", 32'(rd_valid), 32'd0);
        chk("t6_async_busy",  32'(busy),     32'd0);
        step();
        reset = 1'b0;
        repeat (3) begin
            chk("t6_pend_lost", 32'(busy), 32'd0);
            step();
        end
        read = 4'b0100;
        step(); read = '0; step();
        beat("t6_b0", 0, 32'd4, 1'b0);
        beat("t6_b1", 1, 32'd0, 1'b0);
        beat("t6_b2", 2, 32'd0, 1'b0);
        beat("t6_b3", 3, 32'd0, 1'b0);
        beat("t6_b4", 4, 32'd0, 1'b0);
        beat("t6_b5", 5, 32'd0, 1'b1);

        // 5: CW=4 instance, 17 edges on channel 1
`ifdef PERF_CNT_SAT_EN
        exp5 = 15;
`else
        exp5 = 1;
`endif
        for (int k = 0; k < 17; k++) begin
            ex2 = 2'b10; step(); ex2 = '0; step();
        end
        read2 = 2'b01;
        step(); read2 = '0; step();
        beat2("t5_b0", 0, 4'd0, 1'b0, 1'b0);
        beat2("t5_b1", 1, 4'(exp5), 1'b0, 1'b1);
        beat2("t5_b2", 2, 4'd0, 1'b0, 1'b1);
        beat2("t5_b3", 3, 4'(exp5), 1'b1, 1'b1);
        chk("t5_end_valid", 32'(rd_valid2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
